// File: rtl/wb_ddr_bridge_if.sv
// Bus bundle between a Wishbone classic master, the DDR bridge and the DDR controller core.
// The slave modport is the bridge view; the master modport is the view of everything around it.
interface wb_ddr_bridge_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic        wb_ack_o;
  logic        ddr_cmd_valid;
  logic        ddr_cmd_ready;
  logic        ddr_cmd_we;
  logic [27:0] ddr_cmd_adr;
  logic [1:0]  ddr_wword;
  logic [31:0] ddr_wdat;
  logic [3:0]  ddr_wsel;
  logic [31:0] ddr_rdat;
  logic        ddr_rvalid;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
    input  ddr_cmd_ready, ddr_rdat, ddr_rvalid,
    output wb_dat_o, wb_ack_o,
    output ddr_cmd_valid, ddr_cmd_we, ddr_cmd_adr, ddr_wword, ddr_wdat, ddr_wsel
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
    output ddr_cmd_ready, ddr_rdat, ddr_rvalid,
    input  wb_dat_o, wb_ack_o,
    input  ddr_cmd_valid, ddr_cmd_we, ddr_cmd_adr, ddr_wword, ddr_wdat, ddr_wsel
  );
endinterface

// File: rtl/wb_ddr_bridge.sv
// Wishbone classic slave in front of the DDR core: one-line read buffer, write-through writes.
// Read misses fetch a 4-word line; writes become single masked word commands.
module wb_ddr_bridge #(
  parameter bit USE_BUFFER = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  wb_ddr_bridge_if.slave bus,
  input  logic           inv_i,
  output logic           hit_o,
  output logic           miss_o
);

  typedef enum logic [2:0] {IDLE, HIT_ACK, RD_CMD, RD_FILL, RD_ACK, WR_CMD} state_t;

  state_t      state, state_nxt;
  logic        ack_r;
  logic        buf_valid, inv_seen;
  logic [1:0]  beat, word_q;
  logic [27:0] tag;
  logic [31:0] buf_q [4];

  logic        req, tag_hit, last_beat, wr_update;
  logic        acc_hit, acc_miss, acc_wr, rd_ack, wr_ack, cmd_done, fill_beat, fill_done;
  logic [31:0] rd_data;
  logic        unused_adr_bits;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // A request is never taken while the previous ack is still on the bus.
  assign req             = bus.wb_cyc_i & bus.wb_stb_i & ~bus.wb_ack_o;
  assign tag_hit         = buf_valid & (tag == bus.wb_adr_i[31:4]) & USE_BUFFER;
  assign last_beat       = bus.ddr_rvalid & (beat == 2'd3);
  assign rd_data         = buf_q[word_q];
  assign wr_update       = wr_ack & buf_valid & (tag == bus.ddr_cmd_adr);
  assign bus.wb_ack_o    = ack_r & bus.wb_cyc_i;
  assign unused_adr_bits = ^bus.wb_adr_i[1:0];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (bus.wb_we_i)  state_nxt = WR_CMD;
          else if (tag_hit) state_nxt = HIT_ACK;
          else              state_nxt = RD_CMD;
        end
      end
      HIT_ACK: state_nxt = IDLE;
      RD_CMD:  if (bus.ddr_cmd_ready) state_nxt = RD_FILL;
      RD_FILL: if (last_beat) state_nxt = RD_ACK;
      RD_ACK:  state_nxt = IDLE;
      WR_CMD:  if (bus.ddr_cmd_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    acc_hit   = 1'b0;
    acc_miss  = 1'b0;
    acc_wr    = 1'b0;
    rd_ack    = 1'b0;
    wr_ack    = 1'b0;
    cmd_done  = 1'b0;
    fill_beat = 1'b0;
    fill_done = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (bus.wb_we_i)  acc_wr   = 1'b1;
          else if (tag_hit) acc_hit  = 1'b1;
          else              acc_miss = 1'b1;
        end
      end
      HIT_ACK: rd_ack = 1'b1;
      RD_CMD:  cmd_done = bus.ddr_cmd_ready;
      RD_FILL: begin
        fill_beat = bus.ddr_rvalid;
        fill_done = last_beat;
      end
      RD_ACK:  rd_ack = 1'b1;
      WR_CMD: begin
        cmd_done = bus.ddr_cmd_ready;
        wr_ack   = bus.ddr_cmd_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_r             <= 1'b0;
      bus.wb_dat_o      <= '0;
      bus.ddr_cmd_valid <= 1'b0;
      bus.ddr_cmd_we    <= 1'b0;
      bus.ddr_cmd_adr   <= '0;
      bus.ddr_wword     <= '0;
      bus.ddr_wdat      <= '0;
      bus.ddr_wsel      <= '0;
      hit_o             <= 1'b0;
      miss_o            <= 1'b0;
      buf_valid         <= 1'b0;
      inv_seen          <= 1'b0;
      beat              <= '0;
      word_q            <= '0;
    end else begin
      ack_r  <= rd_ack | wr_ack;
      hit_o  <= acc_hit;
      miss_o <= acc_miss;
      if (rd_ack) bus.wb_dat_o <= rd_data;
      if (acc_hit | acc_miss | acc_wr) word_q <= bus.wb_adr_i[3:2];
      // Command fields are only loaded on acceptance, so they hold while the core stalls.
      if (acc_miss | acc_wr) begin
        bus.ddr_cmd_valid <= 1'b1;
        bus.ddr_cmd_we    <= acc_wr;
        bus.ddr_cmd_adr   <= bus.wb_adr_i[31:4];
      end else if (cmd_done) begin
        bus.ddr_cmd_valid <= 1'b0;
      end
      if (acc_wr) begin
        bus.ddr_wword <= bus.wb_adr_i[3:2];
        bus.ddr_wdat  <= bus.wb_dat_i;
        bus.ddr_wsel  <= bus.wb_sel_i;
      end
      if (acc_miss)       beat <= '0;
      else if (fill_beat) beat <= beat + 2'd1;
      // An invalidate that lands mid-fetch must keep the incoming line from becoming valid.
      if (acc_miss) inv_seen <= 1'b0;
      else if (inv_i && (state == RD_CMD || state == RD_FILL)) inv_seen <= 1'b1;
      if (fill_done)  buf_valid <= ~(inv_seen | inv_i);
      else if (inv_i) buf_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_beat)      buf_q[beat] <= bus.ddr_rdat;
    else if (wr_update) buf_q[bus.ddr_wword] <= merge_bytes(buf_q[bus.ddr_wword], bus.ddr_wdat, bus.ddr_wsel);
    if (fill_done) tag <= bus.ddr_cmd_adr;
  end

endmodule

// File: tb/tb_wb_ddr_bridge.sv
// Directed bench for wb_ddr_bridge: stimulus pushes expected commands, acks and hit/miss
// events into queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_wb_ddr_bridge;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic inv0 = 1'b0, inv1 = 1'b0;
  logic hit0, miss0, hit1, miss1;

  wb_ddr_bridge_if bus0();
  wb_ddr_bridge_if bus1();

  wb_ddr_bridge #(.USE_BUFFER(1'b1)) u0 (
    .clk(clk), .reset(reset), .bus(bus0.slave), .inv_i(inv0), .hit_o(hit0), .miss_o(miss0)
  );
  wb_ddr_bridge #(.USE_BUFFER(1'b0)) u1 (
    .clk(clk), .reset(reset), .bus(bus1.slave), .inv_i(inv1), .hit_o(hit1), .miss_o(miss1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [27:0] adr;
    logic [1:0]  wword;
    logic [31:0] wdat;
    logic [3:0]  wsel;
  } cmd_t;
  typedef struct packed {
    logic        chk;
    logic [31:0] dat;
  } ack_t;

  cmd_t       cmd_q[$];
  ack_t       ack_q[$];
  logic [1:0] ev_q[$];   // {hit, miss}
  cmd_t       mc;
  ack_t       ma;
  logic [1:0] me;
  int n_vec = 0, n_bad = 0;
  int n_cmd1 = 0, n_miss1 = 0, n_hit1 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: got timeout or unexpected event, want none", name);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (bus0.wb_ack_o) begin
        if (ack_q.size() == 0) flag("ack_unexpected");
        else begin
          ma = ack_q.pop_front();
          if (ma.chk) check("ack_dat", bus0.wb_dat_o, ma.dat);
        end
      end
      if (bus0.ddr_cmd_valid && bus0.ddr_cmd_ready) begin
        if (cmd_q.size() == 0) flag("cmd_unexpected");
        else begin
          mc = cmd_q.pop_front();
          check("cmd_we", bus0.ddr_cmd_we, mc.we);
          check("cmd_adr", bus0.ddr_cmd_adr, mc.adr);
          if (mc.we) begin
            check("cmd_wword", bus0.ddr_wword, mc.wword);
            check("cmd_wdat", bus0.ddr_wdat, mc.wdat);
            check("cmd_wsel", bus0.ddr_wsel, mc.wsel);
          end
        end
      end
      if (hit0 || miss0) begin
        if (ev_q.size() == 0) flag("hitmiss_unexpected");
        else begin
          me = ev_q.pop_front();
          check("hitmiss", {hit0, miss0}, me);
        end
      end
      if (bus1.ddr_cmd_valid && bus1.ddr_cmd_ready) n_cmd1++;
      if (miss1) n_miss1++;
      if (hit1)  n_hit1++;
    end
  end

  task automatic check_reset_vals;
    check("rst_ack", bus0.wb_ack_o, 0);
    check("rst_dat_o", bus0.wb_dat_o, 0);
    check("rst_cmd_valid", bus0.ddr_cmd_valid, 0);
    check("rst_cmd_we", bus0.ddr_cmd_we, 0);
    check("rst_cmd_adr", bus0.ddr_cmd_adr, 0);
    check("rst_wword", bus0.ddr_wword, 0);
    check("rst_wdat", bus0.ddr_wdat, 0);
    check("rst_wsel", bus0.ddr_wsel, 0);
    check("rst_hit_miss", {hit0, miss0}, 2'b00);
  endtask

  task automatic wb_go(input logic [31:0] adr, input logic we, input logic [31:0] dat, input logic [3:0] sel);
    @(posedge clk); #1;
    bus0.wb_adr_i = adr;
    bus0.wb_we_i  = we;
    bus0.wb_dat_i = dat;
    bus0.wb_sel_i = sel;
    bus0.wb_cyc_i = 1'b1;
    bus0.wb_stb_i = 1'b1;
  endtask

  task automatic wb_end;
    @(posedge clk); #1;
    bus0.wb_cyc_i = 1'b0;
    bus0.wb_stb_i = 1'b0;
    bus0.wb_we_i  = 1'b0;
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus0.wb_ack_o) begin n = i; break; end
    end
    if (n == 0) flag("ack_timeout");
  endtask

  task automatic wait_cmd;
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus0.ddr_cmd_valid) begin seen = 1'b1; break; end
    end
    if (!seen) flag("cmd_timeout");
  endtask

  task automatic pulse_ready;
    @(posedge clk); #1 bus0.ddr_cmd_ready = 1'b1;
    @(posedge clk); #1 bus0.ddr_cmd_ready = 1'b0;
  endtask

  task automatic pulse_inv;
    @(posedge clk); #1 inv0 = 1'b1;
    @(posedge clk); #1 inv0 = 1'b0;
  endtask

  task automatic send_beats(input logic [31:0] base, input int first, input int n, input int inv_at);
    for (int i = first; i < first + n; i++) begin
      @(posedge clk); #1;
      bus0.ddr_rvalid = 1'b1;
      bus0.ddr_rdat   = base + 32'(i);
      inv0            = (i == inv_at);
    end
    @(posedge clk); #1;
    bus0.ddr_rvalid = 1'b0;
    inv0            = 1'b0;
  endtask

  task automatic miss_read(input logic [31:0] adr, input logic [31:0] base, input logic [31:0] exp,
                           input int hold, input int inv_at);
    int n;
    cmd_q.push_back(cmd_t'{we: 1'b0, adr: adr[31:4], wword: 2'd0, wdat: 32'd0, wsel: 4'd0});
    ev_q.push_back(2'b01);
    ack_q.push_back(ack_t'{chk: 1'b1, dat: exp});
    wb_go(adr, 1'b0, 32'd0, 4'hF);
    wait_cmd();
    for (int k = 0; k < hold; k++) begin
      if (k > 0) @(negedge clk);
      check("cmd_hold", {bus0.ddr_cmd_valid, bus0.ddr_cmd_we, bus0.ddr_cmd_adr}, {1'b1, 1'b0, adr[31:4]});
    end
    pulse_ready();
    send_beats(base, 0, 4, inv_at);
    wait_ack(n);
    check("miss_ack_lat", n, 2);
    wb_end();
  endtask

  task automatic hit_read(input logic [31:0] adr, input logic [31:0] exp);
    int n;
    ev_q.push_back(2'b10);
    ack_q.push_back(ack_t'{chk: 1'b1, dat: exp});
    wb_go(adr, 1'b0, 32'd0, 4'hF);
    wait_ack(n);
    check("hit_ack_lat", n, 3);
    check("hit_no_cmd", bus0.ddr_cmd_valid, 0);
    wb_end();
  endtask

  task automatic do_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    cmd_q.push_back(cmd_t'{we: 1'b1, adr: adr[31:4], wword: adr[3:2], wdat: dat, wsel: sel});
    ack_q.push_back(ack_t'{chk: 1'b0, dat: 32'd0});
    wb_go(adr, 1'b1, dat, sel);
    wait_cmd();
    pulse_ready();
    @(negedge clk);
    check("wr_ack_on_ready", {bus0.wb_ack_o, bus0.ddr_cmd_valid}, 2'b10);
    wb_end();
  endtask

  task automatic u1_read(input logic [31:0] base, input logic [31:0] exp);
    int n = 0;
    bit seen = 1'b0;
    @(posedge clk); #1;
    bus1.wb_adr_i = 32'h10;
    bus1.wb_we_i  = 1'b0;
    bus1.wb_sel_i = 4'hF;
    bus1.wb_cyc_i = 1'b1;
    bus1.wb_stb_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus1.ddr_cmd_valid) begin seen = 1'b1; break; end
    end
    if (!seen) flag("u1_cmd_timeout");
    @(posedge clk); #1 bus1.ddr_cmd_ready = 1'b1;
    @(posedge clk); #1 bus1.ddr_cmd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus1.ddr_rvalid = 1'b1;
      bus1.ddr_rdat   = base + 32'(i);
    end
    @(posedge clk); #1 bus1.ddr_rvalid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus1.wb_ack_o) begin n = i; break; end
    end
    if (n == 0) flag("u1_ack_timeout");
    else check("u1_ack_dat", bus1.wb_dat_o, exp);
    @(posedge clk); #1;
    bus1.wb_cyc_i = 1'b0;
    bus1.wb_stb_i = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    bus0.wb_adr_i = '0; bus0.wb_dat_i = '0; bus0.wb_sel_i = '0;
    bus0.wb_cyc_i = 1'b0; bus0.wb_stb_i = 1'b0; bus0.wb_we_i = 1'b0;
    bus0.ddr_cmd_ready = 1'b0; bus0.ddr_rdat = '0; bus0.ddr_rvalid = 1'b0;
    bus1.wb_adr_i = '0; bus1.wb_dat_i = '0; bus1.wb_sel_i = '0;
    bus1.wb_cyc_i = 1'b0; bus1.wb_stb_i = 1'b0; bus1.wb_we_i = 1'b0;
    bus1.ddr_cmd_ready = 1'b0; bus1.ddr_rdat = '0; bus1.ddr_rvalid = 1'b0;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_vals();

    // Cold miss with a stalled command, then hits from the filled line
    miss_read(32'h14, 32'hA0, 32'h0000_00A1, 3, -1);
    @(posedge clk); #1 bus0.ddr_rvalid = 1'b1; bus0.ddr_rdat = 32'hDEAD_BEEF;
    @(posedge clk); #1 bus0.ddr_rvalid = 1'b0;
    hit_read(32'h1C, 32'h0000_00A3);
    hit_read(32'h10, 32'h0000_00A0);

    // Write-through with byte merge on a hit, and an all-zero-select write
    do_write(32'h18, 32'h1122_3344, 4'h3);
    hit_read(32'h18, 32'h0000_3344);
    do_write(32'h14, 32'hFFFF_FFFF, 4'h0);
    hit_read(32'h14, 32'h0000_00A1);

    // Invalidate while idle, then invalidate during a fill
    pulse_inv();
    miss_read(32'h18, 32'hB0, 32'h0000_00B2, 0, -1);
    hit_read(32'h10, 32'h0000_00B0);
    pulse_inv();
    miss_read(32'h18, 32'hC0, 32'h0000_00C2, 0, 1);
    miss_read(32'h18, 32'hD0, 32'h0000_00D2, 0, -1);
    hit_read(32'h1C, 32'h0000_00D3);

    // Reset after two fill beats
    cmd_q.push_back(cmd_t'{we: 1'b0, adr: 28'h2, wword: 2'd0, wdat: 32'd0, wsel: 4'd0});
    ev_q.push_back(2'b01);
    wb_go(32'h20, 1'b0, 32'd0, 4'hF);
    wait_cmd();
    pulse_ready();
    send_beats(32'hE0, 0, 2, -1);
    @(posedge clk); #1;
    reset = 1'b1;
    bus0.wb_cyc_i = 1'b0;
    bus0.wb_stb_i = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_reset_vals();
    send_beats(32'hE0, 2, 2, -1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("no_ack_after_rst", {bus0.wb_ack_o, bus0.ddr_cmd_valid}, 2'b00);
    end
    miss_read(32'h04, 32'hF0, 32'h0000_00F1, 0, -1);
    miss_read(32'h14, 32'h70, 32'h0000_0071, 0, -1);

    // Buffer disabled: every read goes to DDR
    u1_read(32'h50, 32'h0000_0050);
    u1_read(32'h60, 32'h0000_0060);

    repeat (5) @(negedge clk);
    check("u1_cmds", n_cmd1, 2);
    check("u1_misses", n_miss1, 2);
    check("u1_hits", n_hit1, 0);
    check("ack_q_left", ack_q.size(), 0);
    check("cmd_q_left", cmd_q.size(), 0);
    check("ev_q_left", ev_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
